// File: rtl/pc_fetch_control_pkg.sv
// Shared definitions for the PC / fetch-redirect controller.
//   - XLEN, default reset vector
//   - FUNC3 branch codes for the RV32I conditional branches
//   - controller state encoding (BOOT/RUN/PEND, 2 bits)
package pc_fetch_control_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_PEND = 2'b10
   } state_t;

endpackage

// File: rtl/pc_fetch_control_if.sv
// Bundle between the EX stage / memory / hazard unit and the fetch controller.
//   slave  : controller side (takes EX resolution inputs, drives PC, flushes, stall)
//   master : pipeline side (drives EX resolution inputs, observes PC, flushes, stall)
interface pc_fetch_control_if
   import pc_fetch_control_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);
   logic            EX_VALID;
   logic            EX_BRANCH;
   logic            EX_JUMP;
   logic [2:0]      EX_FUNC3;
   logic            EX_EQ;
   logic            EX_LT;
   logic            EX_LTU;
   logic [XLEN-1:0] EX_TARGET;
   logic            IMEM_BUSYWAIT;
   logic            DMEM_BUSYWAIT;
   logic            LOAD_USE_HAZARD;

   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] PC_PLUS4;
   logic            IMEM_READ;
   logic            PIPE_STALL;
   logic            IF_ID_FLUSH;
   logic            ID_EX_FLUSH;
   logic            MISALIGN;
   logic [CNT_W-1:0] REDIRECT_COUNT;

   modport slave (
      input  EX_VALID, EX_BRANCH, EX_JUMP, EX_FUNC3, EX_EQ, EX_LT, EX_LTU,
             EX_TARGET, IMEM_BUSYWAIT, DMEM_BUSYWAIT, LOAD_USE_HAZARD,
      output PC, PC_PLUS4, IMEM_READ, PIPE_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
             MISALIGN, REDIRECT_COUNT
   );

   modport master (
      output EX_VALID, EX_BRANCH, EX_JUMP, EX_FUNC3, EX_EQ, EX_LT, EX_LTU,
             EX_TARGET, IMEM_BUSYWAIT, DMEM_BUSYWAIT, LOAD_USE_HAZARD,
      input  PC, PC_PLUS4, IMEM_READ, PIPE_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
             MISALIGN, REDIRECT_COUNT
   );

endinterface

// File: rtl/pc_fetch_control_branch_cond.sv
// Conditional-branch evaluator (purely combinational).
//   func3 : FUNC3 of the branch instruction
//   eq    : rs1 == rs2
//   lt    : signed   rs1 < rs2
//   ltu   : unsigned rs1 < rs2
//   cond  : branch condition holds (010/011 never hold)
module pc_fetch_control_branch_cond
   import pc_fetch_control_pkg::*;
(
   input  logic [2:0] func3,
   input  logic       eq,
   input  logic       lt,
   input  logic       ltu,
   output logic       cond
);

   always_comb begin
      cond = 1'b0;
      unique case (func3)
         F3_BEQ:  cond = eq;
         F3_BNE:  cond = ~eq;
         F3_BLT:  cond = lt;
         F3_BGE:  cond = ~lt;
         F3_BLTU: cond = ltu;
         F3_BGEU: cond = ~ltu;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_fetch_control.sv
// Program-counter and fetch-redirect controller for the RV32IM 5-stage pipeline.
//   CLK    : clock, all state on posedge
//   RESET  : asynchronous active-low reset
//   bus    : slave side of pc_fetch_control_if
//            in  : EX_VALID/BRANCH/JUMP/FUNC3, EX_EQ/LT/LTU, EX_TARGET,
//                  IMEM_BUSYWAIT, DMEM_BUSYWAIT, LOAD_USE_HAZARD
//            out : PC, PC_PLUS4, IMEM_READ, PIPE_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
//                  MISALIGN (registered pulse), REDIRECT_COUNT (saturating)
// A redirect resolved during a memory stall is parked in pend_pc and applied
// once, on the first cycle the memories are ready again.
module pc_fetch_control
   import pc_fetch_control_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned CNT_W        = 16
)(
   input  logic               CLK,
   input  logic               RESET,
   pc_fetch_control_if.slave  bus
);

   state_t           state;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pend_pc;
   logic [CNT_W-1:0] cnt;
   logic             misalign;

   logic             cond;
   logic             taken;
   logic             mem_stall;
   logic             redirect;
   logic             capture;
   logic             stall;
   logic             imem_read;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  redir_pc;
   logic [XLEN-1:0]  pc_plus4;

   pc_fetch_control_branch_cond u_cond (
      .func3 (bus.EX_FUNC3),
      .eq    (bus.EX_EQ),
      .lt    (bus.EX_LT),
      .ltu   (bus.EX_LTU),
      .cond  (cond)
   );

   assign taken     = bus.EX_VALID & (bus.EX_JUMP | (bus.EX_BRANCH & cond));
   assign mem_stall = bus.IMEM_BUSYWAIT | bus.DMEM_BUSYWAIT;
   // JALR rule: bit 0 of the computed target is always dropped.
   assign target    = bus.EX_TARGET & ~32'd1;
   assign pc_plus4  = pc + 32'd4;

   always_comb begin
      redirect  = 1'b0;
      capture   = 1'b0;
      stall     = 1'b0;
      imem_read = 1'b0;
      redir_pc  = target;
      unique case (state)
         ST_BOOT: begin
            stall = mem_stall | bus.LOAD_USE_HAZARD;
         end
         ST_RUN: begin
            imem_read = 1'b1;
            redirect  = taken & ~mem_stall;
            capture   = taken & mem_stall;
            // A redirect flushes the ID instruction, so its load-use bubble is moot.
            stall     = mem_stall | (bus.LOAD_USE_HAZARD & ~redirect);
         end
         ST_PEND: begin
            imem_read = 1'b1;
            stall     = 1'b1;
            redirect  = ~mem_stall;
            redir_pc  = pend_pc;
         end
         default: begin
            stall = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= ST_BOOT;
         pc       <= RESET_VECTOR;
         pend_pc  <= '0;
         cnt      <= '0;
         misalign <= 1'b0;
      end else begin
         misalign <= redirect & redir_pc[1];
         if (redirect) begin
            pc <= redir_pc;
            if (cnt != '1) begin
               cnt <= cnt + 1'b1;
            end
         end
         unique case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (capture) begin
                  pend_pc <= target;
                  state   <= ST_PEND;
               end else if (!redirect && !stall) begin
                  pc <= pc_plus4;
               end
            end
            ST_PEND: begin
               if (!mem_stall) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   assign bus.PC             = pc;
   assign bus.PC_PLUS4       = pc_plus4;
   assign bus.IMEM_READ      = imem_read;
   assign bus.PIPE_STALL     = stall;
   assign bus.IF_ID_FLUSH    = redirect;
   assign bus.ID_EX_FLUSH    = redirect;
   assign bus.MISALIGN       = misalign;
   assign bus.REDIRECT_COUNT = cnt;

endmodule

// File: tb/tb_pc_fetch_control.sv
module tb_pc_fetch_control;
   import pc_fetch_control_pkg::*;

   logic clk;
   logic rst_n;

   pc_fetch_control_if #(.CNT_W(16)) bus ();

   pc_fetch_control #(
      .RESET_VECTOR (32'h0000_0000),
      .CNT_W        (16)
   ) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        stall;
      logic        imem;
      logic [31:0] pc_after;
      logic [15:0] cnt_after;
      logic        mis_after;
   } exp_t;

   typedef struct {
      logic        valid;
      logic        branch;
      logic        jump;
      logic [2:0]  f3;
      logic        eq;
      logic        lt;
      logic        ltu;
      logic        luh;
      logic [31:0] tgt;
      logic        exp_flush;
      logic        exp_stall;
   } vec_t;

   exp_t        sbq[$];
   vec_t        tv[16];
   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   logic [31:0] m_pc;
   logic [15:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic valid, input logic branch, input logic jump,
                        input logic [2:0] f3, input logic eq, input logic lt,
                        input logic ltu, input logic [31:0] tgt, input logic imem_bw,
                        input logic dmem_bw, input logic luh);
      bus.EX_VALID        = valid;
      bus.EX_BRANCH       = branch;
      bus.EX_JUMP         = jump;
      bus.EX_FUNC3        = f3;
      bus.EX_EQ           = eq;
      bus.EX_LT           = lt;
      bus.EX_LTU          = ltu;
      bus.EX_TARGET       = tgt;
      bus.IMEM_BUSYWAIT   = imem_bw;
      bus.DMEM_BUSYWAIT   = dmem_bw;
      bus.LOAD_USE_HAZARD = luh;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs are already driven; checks combinational outputs at the negedge,
   // then registered state just after the following posedge.
   task automatic step(input string name, input logic flush, input logic stall,
                       input logic imem, input logic [31:0] pc_after,
                       input logic [15:0] cnt_after, input logic mis_after);
      exp_t e;
      e.flush = flush; e.stall = stall; e.imem = imem;
      e.pc_after = pc_after; e.cnt_after = cnt_after; e.mis_after = mis_after;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk({name, ".if_id_flush"}, {31'd0, bus.IF_ID_FLUSH}, {31'd0, e.flush});
      chk({name, ".id_ex_flush"}, {31'd0, bus.ID_EX_FLUSH}, {31'd0, e.flush});
      chk({name, ".pipe_stall"},  {31'd0, bus.PIPE_STALL},  {31'd0, e.stall});
      chk({name, ".imem_read"},   {31'd0, bus.IMEM_READ},   {31'd0, e.imem});
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({name, ".pc"},        bus.PC,                     e.pc_after);
      chk({name, ".pc_plus4"},  bus.PC_PLUS4,               e.pc_after + 32'd4);
      chk({name, ".count"},     {16'd0, bus.REDIRECT_COUNT}, {16'd0, e.cnt_after});
      chk({name, ".misalign"},  {31'd0, bus.MISALIGN},      {31'd0, e.mis_after});
   endtask

   initial begin
      //         valid br  jmp f3      eq  lt  ltu luh  tgt            flush stall
      tv[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b0}; // BEQ taken
      tv[1]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0}; // BEQ not
      tv[2]  = '{1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0103, 1'b1, 1'b0}; // JALR misaligned
      tv[3]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0}; // plain
      tv[4]  = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0}; // BNE + load-use
      tv[5]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1}; // load-use only
      tv[6]  = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 1'b1, 1'b0}; // BLT taken
      tv[7]  = '{1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 1'b0, 1'b0}; // BGE not
      tv[8]  = '{1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 1'b1, 1'b0}; // BLTU taken
      tv[9]  = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0700, 1'b1, 1'b0}; // BGEU taken
      tv[10] = '{1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0A00, 1'b0, 1'b0}; // f3 010 never
      tv[11] = '{1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0B00, 1'b0, 1'b0}; // f3 011 never
      tv[12] = '{1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0C00, 1'b0, 1'b0}; // bubble JAL
      tv[13] = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0D00, 1'b0, 1'b0}; // BNE not
      tv[14] = '{1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0}; // jump to top
      tv[15] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0}; // wrap to 0

      // Reset state
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.pc",        bus.PC, 32'h0);
      chk("rst.count",     {16'd0, bus.REDIRECT_COUNT}, 32'h0);
      chk("rst.misalign",  {31'd0, bus.MISALIGN}, 32'h0);
      chk("rst.imem_read", {31'd0, bus.IMEM_READ}, 32'h0);
      chk("rst.flush",     {31'd0, bus.IF_ID_FLUSH | bus.ID_EX_FLUSH}, 32'h0);
      chk("rst.stall",     {31'd0, bus.PIPE_STALL}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // BOOT for one cycle, then sequential fetch
      step("boot", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
      step("seq4", 1'b0, 1'b0, 1'b1, 32'h4, 16'd0, 1'b0);
      step("seq8", 1'b0, 1'b0, 1'b1, 32'h8, 16'd0, 1'b0);
      step("seqc", 1'b0, 1'b0, 1'b1, 32'hC, 16'd0, 1'b0);
      m_pc  = 32'hC;
      m_cnt = 16'd0;

      // Table-driven single-cycle resolution
      for (int i = 0; i < 16; i++) begin
         logic [31:0] nxt;
         logic        mis;
         drive(tv[i].valid, tv[i].branch, tv[i].jump, tv[i].f3, tv[i].eq, tv[i].lt,
               tv[i].ltu, tv[i].tgt, 1'b0, 1'b0, tv[i].luh);
         if (tv[i].exp_flush) begin
            nxt = {tv[i].tgt[31:1], 1'b0};
            mis = tv[i].tgt[1];
            m_cnt = m_cnt + 16'd1;
         end else begin
            nxt = tv[i].exp_stall ? m_pc : m_pc + 32'd4;
            mis = 1'b0;
         end
         step($sformatf("vec%0d", i), tv[i].exp_flush, tv[i].exp_stall, 1'b1, nxt, m_cnt, mis);
         m_pc = nxt;
      end

      // BLT taken while DMEM busy for 3 cycles: held, then applied once
      drive(1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1'b0);
      step("pend1", 1'b0, 1'b1, 1'b1, m_pc, m_cnt, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0999, 1'b0, 1'b1, 1'b0);
      step("pend2", 1'b0, 1'b1, 1'b1, m_pc, m_cnt, 1'b0);
      step("pend3", 1'b0, 1'b1, 1'b1, m_pc, m_cnt, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0999, 1'b0, 1'b0, 1'b0);
      m_cnt = m_cnt + 16'd1;
      step("pend_apply", 1'b1, 1'b1, 1'b1, 32'h80, m_cnt, 1'b0);
      idle();
      step("pend_after", 1'b0, 1'b0, 1'b1, 32'h84, m_cnt, 1'b0);

      // Reset mid-PEND discards the parked redirect
      drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
      step("rp_capture", 1'b0, 1'b1, 1'b1, 32'h84, m_cnt, 1'b0);
      #2;
      idle();
      rst_n = 1'b0;
      #1;
      chk("rp.async_pc",    bus.PC, 32'h0);
      chk("rp.async_count", {16'd0, bus.REDIRECT_COUNT}, 32'h0);
      chk("rp.async_imem",  {31'd0, bus.IMEM_READ}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("rp_boot", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
      step("rp_run",  1'b0, 1'b0, 1'b1, 32'h4, 16'd0, 1'b0);

      // Counter saturation: 65535 redirects, then one more
      drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
      repeat (65534) @(posedge clk);
      #1;
      step("sat_reach", 1'b1, 1'b0, 1'b1, 32'h1000, 16'hFFFF, 1'b0);
      step("sat_hold",  1'b1, 1'b0, 1'b1, 32'h1000, 16'hFFFF, 1'b0);
      idle();
      step("sat_idle",  1'b0, 1'b0, 1'b1, 32'h1004, 16'hFFFF, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_control.md
# pc_fetch_control

Program-counter and fetch-redirect controller for the RV32IM 5-stage pipeline. Consumes the BRANCH/JUMP control bits produced by the decoder once the instruction reaches EX. Resolves taken/not-taken from the EX comparator flags and FUNC3, then drives the PC, the IF/ID and ID/EX flush lines, and the global stall. Redirects that arrive during a memory stall are held in a pending register and applied exactly once.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- EX_VALID  in  1  EX stage holds a real (non-bubble) instruction.
- EX_BRANCH  in  1  decoded BRANCH bit of the EX instruction.
- EX_JUMP  in  1  decoded JUMP bit (JAL/JALR).
- EX_FUNC3  in  3  FUNC3 of the EX instruction.
- EX_EQ, EX_LT, EX_LTU  in  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
- EX_TARGET  in  32  ALU-computed branch/jump target.
- IMEM_BUSYWAIT, DMEM_BUSYWAIT  in  1 each  memory not ready.
- LOAD_USE_HAZARD  in  1  hazard unit requests a one-cycle bubble.
- PC  out  32  current fetch address.
- PC_PLUS4  out  32  PC+4, modulo 2^32.
- IMEM_READ  out  1  fetch request.
- PIPE_STALL  out  1  freeze IF/ID (and all stages on memory stall).
- IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  clear the two younger instructions.
- MISALIGN  out  1  one-cycle pulse: applied target has bit 1 set.
- REDIRECT_COUNT  out  CNT_W  number of applied redirects, saturating.

## Operation
- Taken rule: EX_JUMP → taken. EX_BRANCH: FUNC3 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU. FUNC3 010/011 are never taken. Taken requires EX_VALID.
- Target = {EX_TARGET[31:1],1'b0}. Bit 0 is always cleared (JALR rule).
- MEM_STALL = IMEM_BUSYWAIT | DMEM_BUSYWAIT. PIPE_STALL = MEM_STALL | (LOAD_USE_HAZARD & no redirect applied this cycle).
- States:
  - BOOT: IMEM_READ=0, PC held. Always → RUN on the next edge.
  - RUN: IMEM_READ=1.
    - If taken and !MEM_STALL: apply the redirect (PC←target, both flushes=1, counter+1); stay in RUN.
    - If taken and MEM_STALL: capture target into PEND_PC; → PEND. No flush.
    - Otherwise, if !PIPE_STALL: PC←PC+4.
  - PEND: IMEM_READ=1, PIPE_STALL=1, taken inputs ignored. When MEM_STALL is low: PC←PEND_PC, both flushes=1, counter+1; → RUN.
- Redirect beats load-use: the ID instruction is flushed, so PC loads the target and no bubble-stall is asserted.
- REDIRECT_COUNT holds at all-ones.

## Timing
- Reset values: PC=RESET_VECTOR, state=BOOT, PEND_PC=0, REDIRECT_COUNT=0, MISALIGN=0, IMEM_READ=0, flushes=0, PIPE_STALL=0.
- Reset is asynchronous assert and synchronous-edge release. Reset mid-PEND discards the pending redirect.
- Flushes, PIPE_STALL and IMEM_READ are combinational from state and inputs, valid in the cycle they take effect. Flushes are high in the same cycle the PC loads the target.
- Redirect latency:
  - Taken in EX at cycle N with no stall → PC=target after edge N.
  - Under stall → PC=target after the first edge where MEM_STALL=0.
- MISALIGN is registered: high for the one cycle after the edge that loaded a target with bit1=1.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Structure
- Shared header rv32im_defs.vh holds:
  - FUNC3 branch codes.
  - State encodings (BOOT/RUN/PEND, 2 bits).
  - Default RESET_VECTOR.
- One combinational sub-module, branch_cond: FUNC3 + EQ/LT/LTU → taken. Reused by the verification model.

## Test plan
- Reset release, no stalls → BOOT for 1 cycle, then PC steps 0,4,8,12; flushes stay 0.
- BEQ in EX, EX_EQ=1, EX_TARGET=0x40 → both flushes high that cycle; PC=0x40 next; REDIRECT_COUNT=1. Same with EX_EQ=0 → PC+4, no flush.
- JALR with EX_TARGET=0x103 → PC=0x102; MISALIGN pulses one cycle.
- BLT taken to 0x80 while DMEM_BUSYWAIT is high for 3 cycles → PC held with no flush for 3 cycles; flushes asserted on the fourth cycle and PC=0x80 after that edge; count +1, not +4.
- BNE taken together with LOAD_USE_HAZARD=1 → PIPE_STALL=0, flushes=1, PC=target.
- Counter preloaded to 0xFFFF via 65535 taken JALs → stays 0xFFFF after one more redirect. Separately, FUNC3=010 with EX_BRANCH=1 → never redirects.
